// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared types, defaults and LFSR step for the serial CRC-8 link
//
// Purpose: FSM state encoding, default SEED/TAPS constants and the crc_step
// function used by both the serial CRC generator and the serial CRC checker.
// Ports: none (package).

package crc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_WAIT_CRC,
    ST_CHECK,
    ST_REPORT
  } state_t;

  // Widest LFSR crc_step can handle; narrower LFSRs are zero-extended into it.
  localparam int CRC_MAX_W = 32;

  localparam logic [7:0] CRC_SEED_DEFAULT = 8'hD8;
  localparam logic [7:0] CRC_TAPS_DEFAULT = 8'h44;

  // One data-bit step of a right-shifting LFSR of 'width' bits: the feedback
  // enters at the top bit and is XORed into every tapped bit below it.
  // Bits of 'lfsr' at or above 'width' must be zero.
  function automatic logic [CRC_MAX_W-1:0] crc_step(
    input logic [CRC_MAX_W-1:0] lfsr,
    input logic [CRC_MAX_W-1:0] taps,
    input int                   width,
    input logic                 d
  );
    logic                 fb;
    logic [CRC_MAX_W-1:0] sh;
    logic [CRC_MAX_W-1:0] nxt;
    fb  = d ^ lfsr[0];
    sh  = lfsr >> 1;
    nxt = '0;
    for (int i = 0; i < CRC_MAX_W; i++) begin
      if (i < width - 1) begin
        nxt[i] = sh[i] ^ (fb & taps[i]);
      end else if (i == width - 1) begin
        nxt[i] = fb;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/crc_lfsr_core.sv
// rtl/crc_lfsr_core.sv - CRC LFSR register with load, data-step and trailer-shift
//
// Purpose: holds the CRC LFSR shared by the serial generator and checker.
// Ports:
//   clk, rst    clock, synchronous active-high reset (loads SEED)
//   load        reload SEED; combined with step_data it steps from SEED
//   step_data   advance the LFSR by one data bit (din)
//   step_shift  shift right with zero fill (trailer serialisation/compare)
//   din         serial data bit
//   lfsr_lsb    lfsr[0], the next trailer bit

module crc_lfsr_core
  import crc_pkg::*;
#(
  parameter int                   CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] SEED      = CRC_WIDTH'(CRC_SEED_DEFAULT),
  parameter logic [CRC_WIDTH-1:0] TAPS      = CRC_WIDTH'(CRC_TAPS_DEFAULT)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step_data,
  input  logic step_shift,
  input  logic din,
  output logic lfsr_lsb
);

  logic [CRC_WIDTH-1:0] lfsr;
  logic [CRC_WIDTH-1:0] base;
  logic [CRC_WIDTH-1:0] stepped;

  // A frame start both reloads and consumes its first bit in the same cycle.
  assign base    = load ? SEED : lfsr;
  assign stepped = CRC_WIDTH'(crc_step(CRC_MAX_W'(base), CRC_MAX_W'(TAPS),
                                       CRC_WIDTH, din));

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (step_data) begin
      lfsr <= stepped;
    end else if (step_shift) begin
      lfsr <= lfsr >> 1;
    end else if (load) begin
      lfsr <= SEED;
    end
  end

  assign lfsr_lsb = lfsr[0];

endmodule

// File: rtl/crc_serial_checker.sv
// rtl/crc_serial_checker.sv - serial CRC-8 frame checker (receive side)
//
// Purpose: recomputes the CRC over a serial data frame and compares it
// bit-by-bit against the serial CRC trailer that follows.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   DATA, ACTIVE      serial data bit (LSB first) and its qualifier
//   CRC, CRC_VALID    serial trailer bit (lfsr[0] first) and its qualifier
//   DONE              one-cycle pulse with the verdict
//   PASS              frame good; held until the next frame start
//   FRAME_ERR         length/truncation/protocol error; held like PASS
//   TIMEOUT_ERR       trailer did not start in time; held like PASS
//   BUSY              FSM not idle

module crc_serial_checker
  import crc_pkg::*;
#(
  parameter int                   DATA_WIDTH = 8,
  parameter int                   CRC_WIDTH  = 8,
  parameter logic [CRC_WIDTH-1:0] SEED       = CRC_WIDTH'(CRC_SEED_DEFAULT),
  parameter logic [CRC_WIDTH-1:0] TAPS       = CRC_WIDTH'(CRC_TAPS_DEFAULT),
  parameter int                   TIMEOUT    = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic DATA,
  input  logic ACTIVE,
  input  logic CRC,
  input  logic CRC_VALID,
  output logic DONE,
  output logic PASS,
  output logic FRAME_ERR,
  output logic TIMEOUT_ERR,
  output logic BUSY
);

  localparam int DCNT_W = $clog2(DATA_WIDTH + 2);
  localparam int CCNT_W = $clog2(CRC_WIDTH + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [DCNT_W-1:0] DCNT_SAT  = DCNT_W'(DATA_WIDTH + 1);
  localparam logic [DCNT_W-1:0] DCNT_EXP  = DCNT_W'(DATA_WIDTH);
  localparam logic [CCNT_W-1:0] CCNT_LAST = CCNT_W'(CRC_WIDTH - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  state_t            state;
  logic              active_d;
  logic [DCNT_W-1:0] dcnt;
  logic [CCNT_W-1:0] ccnt;
  logic [TCNT_W-1:0] tcnt;
  logic              mism;
  logic              len_bad;

  logic rise;
  logic lfsr_lsb;
  logic cmp;
  logic core_load;
  logic core_step;
  logic core_shift;

  assign rise = ACTIVE & ~active_d;
  assign cmp  = CRC ^ lfsr_lsb;
  assign BUSY = (state != ST_IDLE);

  // LFSR control mirrors the FSM transitions below; REPORT reloads the seed
  // so every verdict path (including error exits) leaves the LFSR clean.
  always_comb begin
    core_load  = 1'b0;
    core_step  = 1'b0;
    core_shift = 1'b0;
    case (state)
      ST_IDLE: begin
        core_load = rise;
        core_step = rise;
      end
      ST_DATA:     core_step  = ACTIVE & ~CRC_VALID;
      ST_WAIT_CRC: core_shift = CRC_VALID;
      ST_CHECK:    core_shift = CRC_VALID & ~ACTIVE;
      ST_REPORT:   core_load  = 1'b1;
      default:     core_load  = 1'b0;
    endcase
  end

  crc_lfsr_core #(
    .CRC_WIDTH (CRC_WIDTH),
    .SEED      (SEED),
    .TAPS      (TAPS)
  ) u_lfsr (
    .clk        (CLK),
    .rst        (RST),
    .load       (core_load),
    .step_data  (core_step),
    .step_shift (core_shift),
    .din        (DATA),
    .lfsr_lsb   (lfsr_lsb)
  );

  // Verdict outputs are written on the transition into REPORT so that DONE
  // and the flags appear together in the REPORT cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      active_d    <= 1'b0;
      dcnt        <= '0;
      ccnt        <= '0;
      tcnt        <= '0;
      mism        <= 1'b0;
      len_bad     <= 1'b0;
      DONE        <= 1'b0;
      PASS        <= 1'b0;
      FRAME_ERR   <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      active_d <= ACTIVE;
      DONE     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            PASS        <= 1'b0;
            FRAME_ERR   <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            mism        <= 1'b0;
            len_bad     <= 1'b0;
            dcnt        <= DCNT_W'(1);
            ccnt        <= '0;
            tcnt        <= '0;
            state       <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (ACTIVE && CRC_VALID) begin
            DONE      <= 1'b1;
            PASS      <= 1'b0;
            FRAME_ERR <= 1'b1;
            state     <= ST_REPORT;
          end else if (ACTIVE) begin
            if (dcnt != DCNT_SAT) begin
              dcnt <= dcnt + 1'b1;
            end
          end else begin
            len_bad <= (dcnt != DCNT_EXP);
            tcnt    <= '0;
            state   <= ST_WAIT_CRC;
          end
        end
        ST_WAIT_CRC: begin
          if (CRC_VALID) begin
            mism  <= cmp;
            ccnt  <= CCNT_W'(1);
            state <= ST_CHECK;
          end else if (rise) begin
            DONE      <= 1'b1;
            PASS      <= 1'b0;
            FRAME_ERR <= 1'b1;
            state     <= ST_REPORT;
          end else if (tcnt == TCNT_LAST) begin
            DONE        <= 1'b1;
            PASS        <= 1'b0;
            FRAME_ERR   <= len_bad;
            TIMEOUT_ERR <= 1'b1;
            state       <= ST_REPORT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (!CRC_VALID || ACTIVE) begin
            DONE      <= 1'b1;
            PASS      <= 1'b0;
            FRAME_ERR <= 1'b1;
            state     <= ST_REPORT;
          end else begin
            mism <= mism | cmp;
            ccnt <= ccnt + 1'b1;
            if (ccnt == CCNT_LAST) begin
              DONE      <= 1'b1;
              PASS      <= ~(mism | cmp) & ~len_bad;
              FRAME_ERR <= len_bad;
              state     <= ST_REPORT;
            end
          end
        end
        ST_REPORT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/crc_serial_checker.md
Name: crc_serial_checker

Overview:
- Receive-side counterpart of the serial LFSR CRC-8 generator.
- Consumes a serial data frame, qualified by ACTIVE, then the serial CRC trailer, qualified by CRC_VALID.
- Recomputes the CRC over the data bits and compares it bit-by-bit against the received trailer.
- Reports PASS or FAIL with frame-error and timeout flags; sits at the receiving end of the serial CRC link.

Parameters:
- DATA_WIDTH, 8, expected number of data bits per frame.
- CRC_WIDTH, 8, LFSR and trailer length.
- SEED, 8'hD8, LFSR value loaded at reset and at every frame start.
- TAPS, 8'h44, XOR tap mask applied to LFSR bits 0..CRC_WIDTH-2.
- TIMEOUT, 16, maximum idle cycles allowed between the end of data and the first CRC bit.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- DATA  in  1  serial data bit, LSB first.
- ACTIVE  in  1  high while DATA carries frame bits.
- CRC  in  1  serial received CRC bit, LSB (lfsr[0]) first.
- CRC_VALID  in  1  high while CRC carries trailer bits.
- DONE  out  1  one-cycle pulse when a verdict is produced.
- PASS  out  1  verdict; held until the next frame start.
- FRAME_ERR  out  1  length, truncation or protocol error; held like PASS.
- TIMEOUT_ERR  out  1  no CRC arrived within TIMEOUT; held like PASS.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-high (RST).
- Reset values: all outputs 0, lfsr=SEED, state=IDLE, all counters 0, active_d=0.
- LFSR step for one data bit d:
  - fb = d ^ lfsr[0]
  - next[CRC_WIDTH-1] = fb
  - next[i] = lfsr[i+1] ^ (fb & TAPS[i]) for i < CRC_WIDTH-1
- CRC compare: during the trailer, each CRC bit is compared with lfsr[0]; the LFSR then shifts right with 0 fill.
- IDLE:
  - A rising ACTIVE (ACTIVE=1, active_d=0) starts a frame.
  - That cycle: clear PASS, FRAME_ERR and TIMEOUT_ERR; set lfsr = step(SEED, DATA); set dcnt=1; go to DATA.
  - ACTIVE held high without a rising edge is ignored.
- DATA:
  - While ACTIVE=1: step the LFSR and increment dcnt, saturating at DATA_WIDTH+1.
  - On ACTIVE=0: set len_bad = (dcnt != DATA_WIDTH), clear tcnt, go to WAIT_CRC.
  - CRC_VALID=1 while ACTIVE=1: protocol error, go to REPORT with FRAME_ERR.
- WAIT_CRC:
  - CRC_VALID=1: compare the first bit, set mism = (CRC ^ lfsr[0]), shift, set ccnt=1, go to CHECK.
  - Otherwise increment tcnt; when tcnt reaches TIMEOUT-1, go to REPORT with TIMEOUT_ERR.
  - A rising ACTIVE: go to REPORT with FRAME_ERR; the new frame is not captured.
- CHECK:
  - CRC_VALID=1: OR the new compare result into mism, shift, increment ccnt.
  - When ccnt reaches CRC_WIDTH on this cycle's bit, go to REPORT.
  - CRC_VALID=0 before CRC_WIDTH bits, or ACTIVE=1: go to REPORT with FRAME_ERR.
- REPORT (one cycle):
  - DONE=1.
  - PASS = !mism & !len_bad & !FRAME_ERR & !TIMEOUT_ERR.
  - FRAME_ERR |= len_bad.
  - Reload lfsr=SEED, go to IDLE.
- Latency: DONE asserts the cycle after the last CRC bit is sampled.
- Back-to-back: a rising ACTIVE in the REPORT cycle is not captured; the earliest frame start is the first IDLE cycle.
- RST mid-frame: the frame is aborted, no DONE is produced, and all outputs return to 0.
- Extra CRC_VALID after CRC_WIDTH bits is ignored in IDLE.

Decomposition:
- Package crc_pkg holds:
  - state encoding IDLE/DATA/WAIT_CRC/CHECK/REPORT;
  - default SEED and TAPS constants;
  - a crc_step function implementing the LFSR step.
- Sub-module crc_lfsr_core:
  - holds lfsr; inputs load, step_data, step_shift, din;
  - exposes lfsr[0];
  - is reusable by the generator.

Test Plan:
- Reset, then data 8'h00 (LSB first, 8 ACTIVE cycles), 2 gap cycles, CRC 8'h14 (LSB first) -> DONE pulse one cycle after the last CRC bit; PASS=1, FRAME_ERR=0, TIMEOUT_ERR=0.
- Same frame with CRC 8'h15 (bit0 flipped) -> DONE, PASS=0, FRAME_ERR=0.
- Data 8'h00, then CRC_VALID low after 5 bits -> DONE the following cycle; PASS=0, FRAME_ERR=1.
- ACTIVE for 7 cycles, then CRC 8'h14 -> DONE, PASS=0, FRAME_ERR=1 (length error).
- Data 8'h00, then no CRC_VALID for 16 cycles -> DONE, PASS=0, TIMEOUT_ERR=1, BUSY=0 afterwards.
- RST=1 for one cycle during the 4th CRC bit -> no DONE; all outputs 0; a following good frame (8'h00 / 8'h14) gives PASS=1.
